// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared memory/bus types and MSHR entry definitions for the load responder.
package sys_defs;

   typedef logic [31:0] ADDR;
   typedef logic [63:0] MEM_BLOCK;
   typedef logic [3:0]  MEM_TAG;

   typedef enum logic [1:0] {
      BYTE   = 2'h0,
      HALF   = 2'h1,
      WORD   = 2'h2,
      DOUBLE = 2'h3
   } MEM_SIZE;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   localparam int N_MSHR_DEFAULT = 4;
   // Wide enough for any practical load queue; narrowed at the module boundary.
   localparam int LQ_TAG_MAX_W   = 16;

   typedef enum logic [1:0] {
      INVALID    = 2'h0,
      WAIT_ISSUE = 2'h1,
      WAIT_DATA  = 2'h2
   } mshr_state_e;

   typedef struct packed {
      mshr_state_e             state;
      ADDR                     addr;
      logic [LQ_TAG_MAX_W-1:0] lq_tag;
      MEM_SIZE                 size;
      MEM_TAG                  mem_tag;
      logic                    dead;
   } mshr_entry_t;

   function automatic ADDR block_align(input ADDR a);
      return {a[31:3], 3'b000};
   endfunction

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

endpackage

// File: rtl/mshr_alloc_pick.sv
// rtl/mshr_alloc_pick.sv - lowest-index pickers for a free MSHR slot and the next slot to issue.
module mshr_alloc_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     free_vec,
   input  logic [N-1:0]     issue_vec,
   output logic             free_any,
   output logic [IDX_W-1:0] free_idx,
   output logic             issue_any,
   output logic [IDX_W-1:0] issue_idx
);

   always_comb begin
      free_any  = |free_vec;
      issue_any = |issue_vec;
      free_idx  = '0;
      issue_idx = '0;
      // Scan downward so the lowest set index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (free_vec[i]) free_idx = IDX_W'(i);
         if (issue_vec[i]) issue_idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/dcache_ld_resp.sv
// rtl/dcache_ld_resp.sv - D-cache load responder: 1-cycle hits, MSHR miss tracking, BUS_LOAD issue, refill.
// Optional DCACHE_LD_STATS_EN adds saturating hit/miss/squash counters.
module dcache_ld_resp
   import sys_defs::*;
#(
   parameter int LQ_SIZE = 128,
   parameter int N_MSHR  = N_MSHR_DEFAULT
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       dc_req_valid,
   input  ADDR                        dc_req_addr,
   input  MEM_SIZE                    dc_req_size,
   input  logic [$clog2(LQ_SIZE)-1:0] dc_req_tag,
   output logic                       dc_req_accept,
   output logic                       dc_load_valid,
   output MEM_BLOCK                   dc_load_data,
   output logic [$clog2(LQ_SIZE)-1:0] dc_load_tag,
   input  logic                       squash_i,
   output ADDR                        cache_rd_addr,
   input  logic                       cache_rd_hit,
   input  MEM_BLOCK                   cache_rd_data,
   output logic                       fill_valid,
   output ADDR                        fill_addr,
   output MEM_BLOCK                   fill_data,
   output BUS_COMMAND                 proc2mem_command,
   output ADDR                        proc2mem_addr,
   input  MEM_TAG                     mem2proc_transaction_tag,
   input  MEM_BLOCK                   mem2proc_data,
   input  MEM_TAG                     mem2proc_data_tag
`ifdef DCACHE_LD_STATS_EN
   ,
   output logic [31:0]                stat_hits,
   output logic [31:0]                stat_misses,
   output logic [31:0]                stat_squashed
`endif
);

   localparam int TAG_W = $clog2(LQ_SIZE);
   localparam int IDX_W = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;

   mshr_entry_t mshr_q [N_MSHR];
   mshr_entry_t mshr_d [N_MSHR];

   logic             resp_valid_q, resp_valid_d;
   logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
   MEM_BLOCK         resp_data_q, resp_data_d;
   logic             fill_valid_q, fill_valid_d;
   ADDR              fill_addr_q, fill_addr_d;
   MEM_BLOCK         fill_data_q, fill_data_d;

   logic [N_MSHR-1:0] free_vec, issue_vec;
   logic              free_any, issue_any;
   logic [IDX_W-1:0]  free_idx, issue_idx;
   logic              ret_hit;
   logic [IDX_W-1:0]  ret_idx;
   logic              issue_fire;
   logic              req_miss;

   always_comb begin
      free_vec  = '0;
      issue_vec = '0;
      for (int i = 0; i < N_MSHR; i++) begin
         free_vec[i]  = (mshr_q[i].state == INVALID);
         issue_vec[i] = (mshr_q[i].state == WAIT_ISSUE);
      end
   end

   mshr_alloc_pick #(
      .N     (N_MSHR),
      .IDX_W (IDX_W)
   ) u_pick (
      .free_vec  (free_vec),
      .issue_vec (issue_vec),
      .free_any  (free_any),
      .free_idx  (free_idx),
      .issue_any (issue_any),
      .issue_idx (issue_idx)
   );

   always_comb begin
      ret_hit = 1'b0;
      ret_idx = '0;
      for (int i = N_MSHR - 1; i >= 0; i--) begin
         if (mem2proc_data_tag != '0 && mshr_q[i].state == WAIT_DATA &&
             mshr_q[i].mem_tag == mem2proc_data_tag) begin
            ret_hit = 1'b1;
            ret_idx = IDX_W'(i);
         end
      end
   end

   // A memory return owns the response slot, so the request port is closed on those cycles.
   assign cache_rd_addr    = dc_req_addr;
   assign dc_req_accept    = dc_req_valid && !squash_i && !ret_hit && (cache_rd_hit || free_any);
   assign req_miss         = dc_req_accept && !cache_rd_hit;
   assign issue_fire       = issue_any && !squash_i;
   assign proc2mem_command = issue_fire ? BUS_LOAD : BUS_NONE;
   assign proc2mem_addr    = mshr_q[issue_idx].addr;

   always_comb begin
      for (int i = 0; i < N_MSHR; i++) mshr_d[i] = mshr_q[i];

      if (issue_fire && mem2proc_transaction_tag != '0) begin
         mshr_d[issue_idx].state   = WAIT_DATA;
         mshr_d[issue_idx].mem_tag = mem2proc_transaction_tag;
      end

      if (ret_hit) mshr_d[ret_idx] = '0;

      // Unissued misses vanish; issued ones must still drain their refill.
      if (squash_i) begin
         for (int i = 0; i < N_MSHR; i++) begin
            if (mshr_d[i].state == WAIT_ISSUE) mshr_d[i] = '0;
            else if (mshr_d[i].state == WAIT_DATA) mshr_d[i].dead = 1'b1;
         end
      end

      if (req_miss) begin
         mshr_d[free_idx].state   = WAIT_ISSUE;
         mshr_d[free_idx].addr    = block_align(dc_req_addr);
         mshr_d[free_idx].lq_tag  = LQ_TAG_MAX_W'(dc_req_tag);
         mshr_d[free_idx].size    = dc_req_size;
         mshr_d[free_idx].mem_tag = '0;
         mshr_d[free_idx].dead    = 1'b0;
      end
   end

   always_comb begin
      resp_valid_d = 1'b0;
      resp_tag_d   = resp_tag_q;
      resp_data_d  = resp_data_q;
      fill_valid_d = ret_hit;
      fill_addr_d  = fill_addr_q;
      fill_data_d  = fill_data_q;

      if (ret_hit) begin
         fill_addr_d = mshr_q[ret_idx].addr;
         fill_data_d = mem2proc_data;
         if (!mshr_q[ret_idx].dead && !squash_i) begin
            resp_valid_d = 1'b1;
            resp_tag_d   = TAG_W'(mshr_q[ret_idx].lq_tag);
            resp_data_d  = mem2proc_data;
         end
      end else if (dc_req_accept && cache_rd_hit) begin
         resp_valid_d = 1'b1;
         resp_tag_d   = dc_req_tag;
         resp_data_d  = cache_rd_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < N_MSHR; i++) mshr_q[i] <= '0;
         resp_valid_q <= 1'b0;
         resp_tag_q   <= '0;
         resp_data_q  <= '0;
         fill_valid_q <= 1'b0;
         fill_addr_q  <= '0;
         fill_data_q  <= '0;
      end else begin
         for (int i = 0; i < N_MSHR; i++) mshr_q[i] <= mshr_d[i];
         resp_valid_q <= resp_valid_d;
         resp_tag_q   <= resp_tag_d;
         resp_data_q  <= resp_data_d;
         fill_valid_q <= fill_valid_d;
         fill_addr_q  <= fill_addr_d;
         fill_data_q  <= fill_data_d;
      end
   end

   assign dc_load_valid = resp_valid_q;
   assign dc_load_tag   = resp_tag_q;
   assign dc_load_data  = resp_data_q;
   assign fill_valid    = fill_valid_q;
   assign fill_addr     = fill_addr_q;
   assign fill_data     = fill_data_q;

`ifdef DCACHE_LD_STATS_EN
   logic [31:0] hits_q, hits_d;
   logic [31:0] misses_q, misses_d;
   logic [31:0] squashed_q, squashed_d;
   logic [31:0] killed_cnt;

   always_comb begin
      killed_cnt = '0;
      if (squash_i) begin
         for (int i = 0; i < N_MSHR; i++) begin
            if (mshr_q[i].state != INVALID && !mshr_q[i].dead) killed_cnt = killed_cnt + 32'd1;
         end
      end
      hits_d     = sat_add32(hits_q, {31'd0, dc_req_accept && cache_rd_hit});
      misses_d   = sat_add32(misses_q, {31'd0, req_miss});
      squashed_d = sat_add32(squashed_q, killed_cnt);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hits_q     <= '0;
         misses_q   <= '0;
         squashed_q <= '0;
      end else begin
         hits_q     <= hits_d;
         misses_q   <= misses_d;
         squashed_q <= squashed_d;
      end
   end

   assign stat_hits     = hits_q;
   assign stat_misses   = misses_q;
   assign stat_squashed = squashed_q;
`endif

endmodule

// File: tb/tb_dcache_ld_resp.sv
// tb/tb_dcache_ld_resp.sv - self-checking bench for dcache_ld_resp: directed scenarios plus randomized traffic.
module tb_dcache_ld_resp;
   import sys_defs::*;

   localparam int N = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       dc_req_valid;
   ADDR        dc_req_addr;
   MEM_SIZE    dc_req_size;
   logic [6:0] dc_req_tag;
   logic       dc_req_accept;
   logic       dc_load_valid;
   MEM_BLOCK   dc_load_data;
   logic [6:0] dc_load_tag;
   logic       squash_i;
   ADDR        cache_rd_addr;
   logic       cache_rd_hit;
   MEM_BLOCK   cache_rd_data;
   logic       fill_valid;
   ADDR        fill_addr;
   MEM_BLOCK   fill_data;
   BUS_COMMAND proc2mem_command;
   ADDR        proc2mem_addr;
   MEM_TAG     mem2proc_transaction_tag;
   MEM_BLOCK   mem2proc_data;
   MEM_TAG     mem2proc_data_tag;
`ifdef DCACHE_LD_STATS_EN
   logic [31:0] stat_hits, stat_misses, stat_squashed;
`endif

   always #5 clock = ~clock;

   dcache_ld_resp #(.LQ_SIZE(128), .N_MSHR(N)) dut (
      .clock                    (clock),
      .reset                    (reset),
      .dc_req_valid             (dc_req_valid),
      .dc_req_addr              (dc_req_addr),
      .dc_req_size              (dc_req_size),
      .dc_req_tag               (dc_req_tag),
      .dc_req_accept            (dc_req_accept),
      .dc_load_valid            (dc_load_valid),
      .dc_load_data             (dc_load_data),
      .dc_load_tag              (dc_load_tag),
      .squash_i                 (squash_i),
      .cache_rd_addr            (cache_rd_addr),
      .cache_rd_hit             (cache_rd_hit),
      .cache_rd_data            (cache_rd_data),
      .fill_valid               (fill_valid),
      .fill_addr                (fill_addr),
      .fill_data                (fill_data),
      .proc2mem_command         (proc2mem_command),
      .proc2mem_addr            (proc2mem_addr),
      .mem2proc_transaction_tag (mem2proc_transaction_tag),
      .mem2proc_data            (mem2proc_data),
      .mem2proc_data_tag        (mem2proc_data_tag)
`ifdef DCACHE_LD_STATS_EN
      ,
      .stat_hits                (stat_hits),
      .stat_misses              (stat_misses),
      .stat_squashed            (stat_squashed)
`endif
   );

   int n_total = 0;
   int n_pass  = 0;

   // Reference view: each slot is an outstanding miss (0 free, 1 awaiting issue, 2 awaiting data).
   int          slot_st [N];
   logic [31:0] slot_addr [N];
   logic [6:0]  slot_lq [N];
   logic [3:0]  slot_mt [N];
   bit          slot_dead [N];

   bit          e_acc, e_load;
   logic [31:0] e_paddr;
   int          e_ret, e_free, e_iss;
   bit          e_ldv, e_fv;
   logic [6:0]  e_ldt;
   logic [63:0] e_ldd, e_fd;
   logic [31:0] e_fa;

   bit          rand_mem = 1'b0;
   bit          mem_busy [16];
   bit          s_acc;
   BUS_COMMAND  s_cmd;
   ADDR         s_paddr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic idle();
      dc_req_valid             = 1'b0;
      dc_req_addr              = '0;
      dc_req_size              = WORD;
      dc_req_tag               = '0;
      squash_i                 = 1'b0;
      cache_rd_hit             = 1'b0;
      cache_rd_data            = '0;
      mem2proc_transaction_tag = '0;
      mem2proc_data            = '0;
      mem2proc_data_tag        = '0;
   endtask

   task automatic model_comb();
      e_ret  = -1;
      e_free = -1;
      e_iss  = -1;
      for (int i = 0; i < N; i++) begin
         if (e_ret < 0 && mem2proc_data_tag != 0 && slot_st[i] == 2 && slot_mt[i] == mem2proc_data_tag) e_ret = i;
         if (e_free < 0 && slot_st[i] == 0) e_free = i;
         if (e_iss < 0 && slot_st[i] == 1) e_iss = i;
      end
      e_acc   = dc_req_valid && !squash_i && e_ret < 0 && (cache_rd_hit || e_free >= 0);
      e_load  = !squash_i && e_iss >= 0;
      e_paddr = (e_iss >= 0) ? slot_addr[e_iss] : 32'h0;
   endtask

   task automatic model_seq(input bit rst);
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            slot_st[i]   = 0;
            slot_dead[i] = 1'b0;
         end
         e_ldv = 1'b0;
         e_fv  = 1'b0;
         return;
      end
      e_fv  = (e_ret >= 0);
      e_ldv = 1'b0;
      if (e_ret >= 0) begin
         e_fa = slot_addr[e_ret];
         e_fd = mem2proc_data;
         if (!slot_dead[e_ret] && !squash_i) begin
            e_ldv = 1'b1;
            e_ldt = slot_lq[e_ret];
            e_ldd = mem2proc_data;
         end
      end else if (e_acc && cache_rd_hit) begin
         e_ldv = 1'b1;
         e_ldt = dc_req_tag;
         e_ldd = cache_rd_data;
      end
      if (e_load && mem2proc_transaction_tag != 0) begin
         slot_st[e_iss] = 2;
         slot_mt[e_iss] = mem2proc_transaction_tag;
      end
      if (e_ret >= 0) slot_st[e_ret] = 0;
      if (squash_i) begin
         for (int i = 0; i < N; i++) begin
            if (slot_st[i] == 1) slot_st[i] = 0;
            else if (slot_st[i] == 2) slot_dead[i] = 1'b1;
         end
      end
      if (e_acc && !cache_rd_hit) begin
         slot_st[e_free]   = 1;
         slot_addr[e_free] = dc_req_addr & ~32'h7;
         slot_lq[e_free]   = dc_req_tag;
         slot_dead[e_free] = 1'b0;
      end
   endtask

   task automatic pick_ttag();
      int start;
      if (e_load && !reset) begin
         mem2proc_transaction_tag = '0;
         if ($urandom_range(0, 9) >= 3) begin
            start = $urandom_range(1, 15);
            for (int k = 0; k < 15; k++) begin
               int t;
               t = ((start - 1 + k) % 15) + 1;
               if (!mem_busy[t] && mem2proc_transaction_tag == 0) begin
                  mem2proc_transaction_tag = MEM_TAG'(t);
                  mem_busy[t] = 1'b1;
               end
            end
         end
      end else begin
         mem2proc_transaction_tag = MEM_TAG'($urandom_range(0, 15));
      end
   endtask

   // Inputs are already applied (just after a falling edge); run one clock and check both phases.
   task automatic tick();
      bit was_reset;
      was_reset = reset;
      model_comb();
      if (rand_mem) pick_ttag();
      #1;
      s_acc   = dc_req_accept;
      s_cmd   = proc2mem_command;
      s_paddr = proc2mem_addr;
      if (!was_reset) begin
         chk("accept", 64'(s_acc), 64'(e_acc));
         chk("bus_cmd", 64'(s_cmd), 64'(e_load ? BUS_LOAD : BUS_NONE));
         if (e_load) chk("bus_addr", 64'(s_paddr), 64'(e_paddr));
         chk("cache_rd_addr", 64'(cache_rd_addr), 64'(dc_req_addr));
      end
      model_seq(was_reset);
      @(negedge clock);
      chk("load_valid", 64'(dc_load_valid), 64'(e_ldv));
      chk("fill_valid", 64'(fill_valid), 64'(e_fv));
      if (was_reset) begin
         chk("rst_load_tag", 64'(dc_load_tag), 64'h0);
         chk("rst_load_data", dc_load_data, 64'h0);
      end
      if (e_ldv) begin
         chk("load_tag", 64'(dc_load_tag), 64'(e_ldt));
         chk("load_data", dc_load_data, e_ldd);
      end
      if (e_fv) begin
         chk("fill_addr", 64'(fill_addr), 64'(e_fa));
         chk("fill_data", fill_data, e_fd);
      end
   endtask

   task automatic miss_req(input logic [6:0] tag, input logic [31:0] addr);
      idle();
      dc_req_valid = 1'b1;
      dc_req_tag   = tag;
      dc_req_addr  = addr;
      tick();
   endtask

   task automatic rand_inputs();
      int nb;
      int pick;
      idle();
      reset         = ($urandom_range(0, 199) == 0);
      dc_req_valid  = ($urandom_range(0, 9) < 6);
      dc_req_addr   = $urandom & 32'h0000_0FFF;
      dc_req_size   = MEM_SIZE'($urandom_range(0, 3));
      dc_req_tag    = 7'($urandom_range(0, 127));
      squash_i      = ($urandom_range(0, 29) == 0);
      cache_rd_hit  = ($urandom_range(0, 9) < 4);
      cache_rd_data = {$urandom, $urandom};
      mem2proc_data = {$urandom, $urandom};
      nb = 0;
      for (int t = 1; t < 16; t++) if (mem_busy[t]) nb++;
      if (nb > 0 && $urandom_range(0, 99) < 35) begin
         pick = $urandom_range(0, nb - 1);
         for (int t = 1; t < 16; t++) begin
            if (mem_busy[t]) begin
               if (pick == 0) begin
                  mem2proc_data_tag = MEM_TAG'(t);
                  mem_busy[t] = 1'b0;
               end
               pick--;
            end
         end
      end else if ($urandom_range(0, 99) < 5) begin
         for (int t = 1; t < 16; t++) if (!mem_busy[t] && mem2proc_data_tag == 0) mem2proc_data_tag = MEM_TAG'(t);
      end
   endtask

   initial begin
      idle();
      reset = 1'b1;
      @(negedge clock);
      tick();
      chk("reset_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
      reset = 1'b0;

      // Hit path
      idle();
      dc_req_valid  = 1'b1;
      dc_req_tag    = 7'd5;
      dc_req_addr   = 32'h100;
      cache_rd_hit  = 1'b1;
      cache_rd_data = 64'hDEAD_BEEF_0000_0001;
      tick();
      chk("t1_accept", 64'(s_acc), 64'h1);
      chk("t1_cmd", 64'(s_cmd), 64'(BUS_NONE));
      chk("t1_valid", 64'(dc_load_valid), 64'h1);
      chk("t1_tag", 64'(dc_load_tag), 64'd5);
      chk("t1_data", dc_load_data, 64'hDEAD_BEEF_0000_0001);

      // Miss with one rejected issue
      miss_req(7'd9, 32'h204);
      chk("t2_accept", 64'(s_acc), 64'h1);
      chk("t2_cmd_alloc", 64'(s_cmd), 64'(BUS_NONE));
      idle();
      tick();
      chk("t2_cmd_retry", 64'(s_cmd), 64'(BUS_LOAD));
      chk("t2_addr", 64'(s_paddr), 64'h200);
      idle();
      mem2proc_transaction_tag = 4'd3;
      tick();
      chk("t2_cmd_take", 64'(s_cmd), 64'(BUS_LOAD));
      idle();
      tick();
      chk("t2_cmd_quiet", 64'(s_cmd), 64'(BUS_NONE));
      idle();
      mem2proc_data_tag = 4'd3;
      mem2proc_data     = 64'h1234;
      tick();
      chk("t2_fill_valid", 64'(fill_valid), 64'h1);
      chk("t2_fill_addr", 64'(fill_addr), 64'h200);
      chk("t2_load_tag", 64'(dc_load_tag), 64'd9);
      chk("t2_load_data", dc_load_data, 64'h1234);

      // Full table refuses misses but still takes hits
      for (int i = 0; i < 4; i++) miss_req(7'(10 + i), 32'h1000 + 32'(i * 64));
      miss_req(7'd14, 32'h2000);
      chk("t3_full_refuse", 64'(s_acc), 64'h0);
      idle();
      dc_req_valid  = 1'b1;
      dc_req_tag    = 7'd15;
      dc_req_addr   = 32'h3000;
      cache_rd_hit  = 1'b1;
      cache_rd_data = 64'h5555;
      tick();
      chk("t3_full_hit", 64'(s_acc), 64'h1);
      chk("t3_hit_tag", 64'(dc_load_tag), 64'd15);
      begin
         logic [3:0] mtags [4];
         mtags = '{4'd1, 4'd2, 4'd4, 4'd5};
         for (int i = 0; i < 4; i++) begin
            idle();
            mem2proc_transaction_tag = mtags[i];
            tick();
         end
      end

      // Return collides with a hit request
      idle();
      mem2proc_data_tag = 4'd2;
      mem2proc_data     = 64'hAAAA;
      dc_req_valid      = 1'b1;
      dc_req_tag        = 7'd7;
      dc_req_addr       = 32'h400;
      cache_rd_hit      = 1'b1;
      cache_rd_data     = 64'h7777;
      tick();
      chk("t4_blocked", 64'(s_acc), 64'h0);
      chk("t4_ret_tag", 64'(dc_load_tag), 64'd11);
      chk("t4_fill_addr", 64'(fill_addr), 64'h1040);
      mem2proc_data_tag = '0;
      tick();
      chk("t4_retry_acc", 64'(s_acc), 64'h1);
      chk("t4_hit_tag", 64'(dc_load_tag), 64'd7);
      chk("t4_hit_data", dc_load_data, 64'h7777);
      begin
         logic [3:0] rtags [3];
         rtags = '{4'd1, 4'd4, 4'd5};
         for (int i = 0; i < 3; i++) begin
            idle();
            mem2proc_data_tag = rtags[i];
            mem2proc_data     = 64'(100 + i);
            tick();
         end
      end

      // Squash with one unissued and one issued miss
      miss_req(7'd20, 32'h500);
      idle();
      mem2proc_transaction_tag = 4'd4;
      tick();
      miss_req(7'd21, 32'h600);
      idle();
      squash_i = 1'b1;
      mem2proc_transaction_tag = 4'd6;
      tick();
      chk("t5_no_issue", 64'(s_cmd), 64'(BUS_NONE));
      idle();
      tick();
      chk("t5_freed", 64'(s_cmd), 64'(BUS_NONE));
      idle();
      mem2proc_data_tag = 4'd4;
      mem2proc_data     = 64'h4444;
      tick();
      chk("t5_fill_valid", 64'(fill_valid), 64'h1);
      chk("t5_fill_addr", 64'(fill_addr), 64'h500);
      chk("t5_dead_silent", 64'(dc_load_valid), 64'h0);
      for (int i = 0; i < 4; i++) begin
         miss_req(7'(40 + i), 32'h900 + 32'(i * 8));
         chk("t5_table_free", 64'(s_acc), 64'h1);
      end

      // Reset with misses in flight, then a stale return
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      miss_req(7'd30, 32'h700);
      miss_req(7'd31, 32'h800);
      idle();
      mem2proc_transaction_tag = 4'd7;
      tick();
      idle();
      mem2proc_transaction_tag = 4'd8;
      tick();
      idle();
      reset = 1'b1;
      tick();
      chk("t6_rst_valid", 64'(dc_load_valid), 64'h0);
      chk("t6_rst_fill", 64'(fill_valid), 64'h0);
      reset = 1'b0;
      idle();
      tick();
      chk("t6_cmd_none", 64'(s_cmd), 64'(BUS_NONE));
      idle();
      mem2proc_data_tag = 4'd7;
      mem2proc_data     = 64'h7070;
      tick();
      chk("t6_stale_load", 64'(dc_load_valid), 64'h0);
      chk("t6_stale_fill", 64'(fill_valid), 64'h0);

      // Randomized traffic against the reference view
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int t = 0; t < 16; t++) mem_busy[t] = 1'b0;
      rand_mem = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         rand_inputs();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
